mult_row_scheduler: RTL
=======================

# mult_row_scheduler

Drains the per-channel product FIFOs of the multiply channel into per-channel row accumulators and emits one finished dot-product per row. Products are popped at most one per cycle under round-robin arbitration, so a single adder is time-shared across all channels. Sits between the multiply channel outputs and the result writer; row lengths arrive from the matrix-row decoder.

## Interface
- channel_num, 4: number of multiply channels / product FIFOs
- val_bits, 16: operand width; products are 2*val_bits signed
- len_bits, 16: row-length width
- acc_bits, 2*val_bits+8: accumulator and result width, signed
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mult  in  channel_num*2*val_bits  product FIFO data, channel i at [i*2*val_bits +: 2*val_bits]
- mult_fifo_empty  in  channel_num  product FIFO empty flags
- mult_fifo_read  out  channel_num  product FIFO pop, one-hot or zero
- row_len  in  channel_num*len_bits  product count of next row per channel
- row_len_valid  in  channel_num  row_len[i] valid
- row_len_ready  out  channel_num  channel i accepts a row length
- res  out  acc_bits  finished row sum
- res_chan  out  $clog2(channel_num)  channel that produced res
- res_valid  out  1  res/res_chan valid
- res_ready  in  1  downstream accepts res

## Operation
- Per-channel FSM: IDLE -> ACTIVE on row_len handshake (row_len_valid[i] && row_len_ready[i]); row_len_ready[i] = (state==IDLE). Handshake loads remaining<=row_len, acc[i]<=0.
- ACTIVE -> DRAIN when the read of the last product (remaining==1) is issued; DRAIN -> IDLE in the cycle its result is written into the output register.
- Zero-length row: IDLE -> DRAIN directly; granted like a last product but no FIFO read; result 0.
- Request i = ACTIVE && !mult_fifo_empty[i], or DRAIN-pending zero-length row. A request that completes a row is masked unless (!res_valid || res_ready) and no completing product is in stage 1.
- Round-robin: pointer reset to 0; winner = first requester at or after pointer; pointer <= winner+1 mod channel_num. No requester: no read, pointer holds.
- Grant k: mult_fifo_read[k]=1, remaining[k]--, stage-1 reg captures {valid, k, last}.
- Stage 1: mult slice k sign-extended to acc_bits, acc[k] <= acc[k]+product. If last: res<=acc[k]+product, res_chan<=k, res_valid<=1.
- res_valid holds, res/res_chan stable until res_ready sampled high.
- Arithmetic: two's-complement, wrap on overflow at acc_bits (see Configuration).

## Timing
- mult_fifo_read combinational from registered state and current empty flags; FIFO dout valid one cycle after read.
- Read in cycle t; accumulate at edge ending t+1; last product -> res_valid high in cycle t+2.
- Peak throughput 1 product/cycle aggregate; a non-empty active channel is granted within channel_num cycles unless blocked by result backpressure.
- Simultaneous row_len handshake and result write for the same channel: impossible (IDLE vs DRAIN); handshakes on different channels in the same cycle all accepted.
- Reset (any time, mid-row included): all FSMs IDLE, acc=0, remaining=0, pointer=0, stage 1 invalid, mult_fifo_read=0, row_len_ready=all ones after release, res=0, res_chan=0, res_valid=0. Product FIFOs are not cleared by this block.

## Configuration
- ACC_SAT_EN defined: stage-1 add saturates to +/-(2^(acc_bits-1)) bounds (max 2^(acc_bits-1)-1); res carries the saturated value.
- Not defined: plain wrap-around add.

## Structure
- Shared package: val_bits, len_bits, acc_bits, channel_num, channel FSM state enum (IDLE, ACTIVE, DRAIN), chan-index width.
- One sub-module: rr_arbiter (channel_num requests, rotating pointer, one-hot grant, grant index).

## Test plan
- Single row, ch0 len 3, products 5,-2,7 -> res=10, res_chan=0, res_valid 2 cycles after third read.
- ch0..ch3 len 2, all FIFOs full of 1 -> grants 0,1,2,3,0,1,2,3; four results of 2 in channel order.
- res_ready held low with two rows finishing -> second last-product read withheld; both results delivered after release, none lost.
- ch2 len 0 -> res=0, res_chan=2, no mult_fifo_read[2] pulse.
- rst low mid-row (ch1 remaining 4) -> all outputs at reset values next edge; new len 1, product 9 -> res=9.
- Products of +2^31-1 x 300 with acc_bits 40 -> wrap without macro, clamp to 2^39-1 with ACC_SAT_EN.

Source files
------------

// File: rtl/mult_row_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// mult_row_scheduler_pkg
// Shared sizes, channel FSM state type and the accumulator add helper used by
// the row scheduler and its arbiter.
//
// Build option:
//   ACC_SAT_EN - when defined the accumulator add saturates at the signed
//                ACC_BITS bounds instead of wrapping.
// -----------------------------------------------------------------------------
package mult_row_scheduler_pkg;

  localparam int CHANNEL_NUM = 4;
  localparam int VAL_BITS    = 16;
  localparam int LEN_BITS    = 16;
  localparam int PROD_BITS   = 2 * VAL_BITS;
  localparam int ACC_BITS    = 2 * VAL_BITS + 8;
  localparam int CHAN_W      = $clog2(CHANNEL_NUM);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } chan_state_e;

  // Signed accumulate: wrap-around by default, clamp when ACC_SAT_EN is set.
  function automatic logic [ACC_BITS-1:0] acc_add(input logic [ACC_BITS-1:0] a,
                                                    input logic [ACC_BITS-1:0] b);
`ifdef ACC_SAT_EN
    logic [ACC_BITS:0] s;
    s = {a[ACC_BITS-1], a} + {b[ACC_BITS-1], b};
    // Sign-extension bit disagreeing with the MSB means the true sum left range.
    if (s[ACC_BITS] != s[ACC_BITS-1]) begin
      return s[ACC_BITS] ? {1'b1, {(ACC_BITS-1){1'b0}}} : {1'b0, {(ACC_BITS-1){1'b1}}};
    end
    return s[ACC_BITS-1:0];
`else
    return a + b;
`endif
  endfunction

endpackage

// File: rtl/mult_row_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mult_row_scheduler_rr_arbiter
// Round-robin arbiter: grants the first requester at or after a rotating
// pointer. The pointer moves to winner+1 on a grant and holds otherwise.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   i_req          per-channel request
//   o_grant        one-hot grant (zero when no request)
//   o_grant_idx    index of the granted channel
//   o_grant_valid  a grant is issued this cycle
// -----------------------------------------------------------------------------
module mult_row_scheduler_rr_arbiter
  import mult_row_scheduler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHANNEL_NUM-1:0] i_req,
  output logic [CHANNEL_NUM-1:0] o_grant,
  output logic [CHAN_W-1:0]      o_grant_idx,
  output logic                   o_grant_valid
);

  logic [CHAN_W-1:0] r_ptr;

  always_comb begin
    logic [CHAN_W-1:0] w_idx;
    w_idx         = '0;
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    for (int off = 0; off < CHANNEL_NUM; off++) begin
      w_idx = CHAN_W'((int'(r_ptr) + off) % CHANNEL_NUM);
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant_valid  = 1'b1;
        o_grant_idx    = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (o_grant_valid) begin
      r_ptr <= (o_grant_idx == CHAN_W'(CHANNEL_NUM - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mult_row_scheduler.sv
// -----------------------------------------------------------------------------
// mult_row_scheduler
// Pops products from per-channel FIFOs (at most one per cycle, round-robin),
// accumulates them per row through one shared adder stage and emits one
// finished dot-product per row.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   mult             FIFO data, channel i at [i*PROD_BITS +: PROD_BITS]
//   mult_fifo_empty  FIFO empty flags
//   mult_fifo_read   FIFO pop (one-hot or zero), data valid the next cycle
//   row_len*         per-channel row-length valid/ready handshake
//   res, res_chan    finished row sum and its channel
//   res_valid/ready  result handshake; res/res_chan held while not accepted
//   dbg_state        per-channel FSM state, channel i at [2*i +: 2]
//
// Build option: ACC_SAT_EN selects saturating accumulation (see package).
//
// Handshakes: a transfer occurs on a rising edge where valid and ready are
// both high; valid, once raised, holds with stable payload until that edge.
// -----------------------------------------------------------------------------
module mult_row_scheduler
  import mult_row_scheduler_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNEL_NUM*PROD_BITS-1:0] mult,
  input  logic [CHANNEL_NUM-1:0]         mult_fifo_empty,
  output logic [CHANNEL_NUM-1:0]         mult_fifo_read,
  input  logic [CHANNEL_NUM*LEN_BITS-1:0] row_len,
  input  logic [CHANNEL_NUM-1:0]         row_len_valid,
  output logic [CHANNEL_NUM-1:0]         row_len_ready,
  output logic [ACC_BITS-1:0]            res,
  output logic [CHAN_W-1:0]              res_chan,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [CHANNEL_NUM*2-1:0]       dbg_state
);

  chan_state_e          r_state     [CHANNEL_NUM];
  logic [LEN_BITS-1:0]  r_remaining [CHANNEL_NUM];
  logic [ACC_BITS-1:0]  r_acc       [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0] r_zero_pend;  // zero-length row waiting for its slot

  logic                 r_s1_valid;
  logic [CHAN_W-1:0]    r_s1_chan;
  logic                 r_s1_last;
  logic                 r_s1_zero;

  logic [ACC_BITS-1:0]  r_res;
  logic [CHAN_W-1:0]    r_res_chan;
  logic                 r_res_valid;

  logic [PROD_BITS-1:0] w_prod_arr [CHANNEL_NUM];
  logic [LEN_BITS-1:0]  w_len_arr  [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0] w_last;
  logic [CHANNEL_NUM-1:0] w_req;
  logic [CHANNEL_NUM-1:0] w_grant;
  logic [CHAN_W-1:0]    w_grant_idx;
  logic                 w_grant_valid;
  logic                 w_out_free;
  logic [PROD_BITS-1:0] w_s1_prod;
  logic [ACC_BITS-1:0]  w_s1_prod_ext;
  logic [ACC_BITS-1:0]  w_sum;

  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_chan
    assign w_prod_arr[g]          = mult[g*PROD_BITS +: PROD_BITS];
    assign w_len_arr[g]           = row_len[g*LEN_BITS +: LEN_BITS];
    assign row_len_ready[g]       = (r_state[g] == ST_IDLE);
    assign dbg_state[g*2 +: 2]    = r_state[g];
  end

  // A row-completing grant is only safe when the output register will be free
  // by the time stage 1 writes it: no unaccepted result and no completion
  // already sitting in stage 1.
  assign w_out_free = (!r_res_valid || res_ready) && !(r_s1_valid && r_s1_last);

  always_comb begin
    w_last = '0;
    w_req  = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      w_last[i] = r_zero_pend[i] ||
                  (r_state[i] == ST_ACTIVE && r_remaining[i] == LEN_BITS'(1));
      w_req[i]  = ((r_state[i] == ST_ACTIVE && !mult_fifo_empty[i]) || r_zero_pend[i]) &&
                  (!w_last[i] || w_out_free);
    end
  end

  mult_row_scheduler_rr_arbiter u_arb (
    .clk           (clk),
    .rst           (rst),
    .i_req         (w_req),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  // Zero-length rows take a grant slot but never touch their FIFO.
  assign mult_fifo_read = w_grant & ~r_zero_pend;

  assign w_s1_prod     = r_s1_zero ? '0 : w_prod_arr[r_s1_chan];
  assign w_s1_prod_ext = {{(ACC_BITS-PROD_BITS){w_s1_prod[PROD_BITS-1]}}, w_s1_prod};
  assign w_sum         = acc_add(r_acc[r_s1_chan], w_s1_prod_ext);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        r_state[i]     <= ST_IDLE;
        r_remaining[i] <= '0;
        r_acc[i]       <= '0;
      end
      r_zero_pend <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_chan   <= '0;
      r_s1_last   <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_res       <= '0;
      r_res_chan  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        if (row_len_valid[i] && r_state[i] == ST_IDLE) begin
          r_remaining[i] <= w_len_arr[i];
          r_acc[i]       <= '0;
          if (w_len_arr[i] == '0) begin
            r_state[i]     <= ST_DRAIN;
            r_zero_pend[i] <= 1'b1;
          end else begin
            r_state[i] <= ST_ACTIVE;
          end
        end else if (w_grant[i]) begin
          if (r_zero_pend[i]) begin
            r_zero_pend[i] <= 1'b0;
          end else begin
            r_remaining[i] <= r_remaining[i] - 1'b1;
            if (r_remaining[i] == LEN_BITS'(1)) r_state[i] <= ST_DRAIN;
          end
        end
        // Stage 1 on a channel never coincides with its handshake (DRAIN/ACTIVE).
        if (r_s1_valid && r_s1_chan == CHAN_W'(i)) begin
          r_acc[i] <= w_sum;
          if (r_s1_last) r_state[i] <= ST_IDLE;
        end
      end

      r_s1_valid <= w_grant_valid;
      r_s1_chan  <= w_grant_idx;
      r_s1_last  <= w_grant_valid && w_last[w_grant_idx];
      r_s1_zero  <= w_grant_valid && r_zero_pend[w_grant_idx];

      if (r_s1_valid && r_s1_last) begin
        r_res       <= w_sum;
        r_res_chan  <= r_s1_chan;
        r_res_valid <= 1'b1;
      end else if (res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res       = r_res;
  assign res_chan  = r_res_chan;
  assign res_valid = r_res_valid;

endmodule
